// File: rtl/riscv_issue_pkg.sv
// Shared types for the dual-issue scheduler: FU codes, the decoded descriptor layout
// and the operand-ready helper.
package riscv_issue_pkg;

    typedef enum logic [1:0] {
        FU_ALU    = 2'b00,
        FU_LS     = 2'b01,
        FU_MULDIV = 2'b10
    } fu_e;

    localparam int unsigned DESC_W     = 15;
    localparam int unsigned RS0_LSB    = 0;
    localparam int unsigned RS0_EN_BIT = 5;
    localparam int unsigned RS1_LSB    = 6;
    localparam int unsigned RS1_EN_BIT = 11;
    localparam int unsigned RD_EN_BIT  = 12;
    localparam int unsigned FUNC_LSB   = 13;

    typedef struct packed {
        fu_e        func;
        logic       rd_en;
        logic       rs1_en;
        logic [4:0] rs1;
        logic       rs0_en;
        logic [4:0] rs0;
    } desc_t;

    function automatic desc_t unpack_desc(input logic [DESC_W-1:0] raw);
        desc_t d;
        d.func   = fu_e'(raw[FUNC_LSB +: 2]);
        d.rd_en  = raw[RD_EN_BIT];
        d.rs1_en = raw[RS1_EN_BIT];
        d.rs1    = raw[RS1_LSB +: 5];
        d.rs0_en = raw[RS0_EN_BIT];
        d.rs0    = raw[RS0_LSB +: 5];
        return d;
    endfunction

    function automatic logic op_rdy(input logic en, input logic [4:0] rs,
                                    input logic [31:0] src_ready);
        return !en || src_ready[rs];
    endfunction

endpackage

// File: rtl/riscv_issue_queue.sv
// Circular issue queue: enqueues up to two descriptors at the tail and retires up to
// two at the head per cycle; flush empties it and drops that cycle's enqueue.
module riscv_issue_queue
    import riscv_issue_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [1:0]  enq_val,
    input  desc_t       enq_desc0,
    input  desc_t       enq_desc1,
    input  logic [1:0]  deq_cnt,
    output logic        enq_rdy,
    output desc_t       head_desc,
    output desc_t       next_desc,
    output logic        head_val,
    output logic        next_val
);

    localparam int unsigned QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = QW + 1;

    desc_t          mem [QDEPTH];
    logic [QW-1:0]  head;
    logic [QW-1:0]  tail;
    logic [CW-1:0]  count;
    logic [1:0]     enq_cnt;

    assign enq_rdy   = (count <= CW'(QDEPTH - 2));
    assign head_val  = (count != '0);
    assign next_val  = (count >= CW'(2));
    assign head_desc = mem[head];
    assign next_desc = mem[head + QW'(1)];

    always_comb begin
        enq_cnt = '0;
        if (enq_rdy && enq_val[0] && !flush)
            enq_cnt = enq_val[1] ? 2'd2 : 2'd1;
    end

    always_ff @(posedge clk) begin
        if (enq_cnt != '0)
            mem[tail] <= enq_desc0;
        if (enq_cnt == 2'd2)
            mem[tail + QW'(1)] <= enq_desc1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= tail;
            count <= '0;
        end else begin
            tail  <= tail + QW'(enq_cnt);
            head  <= head + QW'(deq_cnt);
            count <= count + CW'(enq_cnt) - CW'(deq_cnt);
        end
    end

endmodule

// File: rtl/riscv_core_issue_sched.sv
// In-order dual-issue scheduler: head to pipe A, head+1 to pipe B (ALU only),
// with ROB slot allocation and MULDIV occupancy tracking.
module riscv_core_issue_sched
    import riscv_issue_pkg::*;
#(
    parameter int unsigned QDEPTH    = 4,
    parameter int unsigned ROB_SLOTS = 32,
    parameter int unsigned MD_OCC    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  enq_val,
    output logic        enq_rdy,
    input  logic [14:0] enq_desc0,
    input  logic [14:0] enq_desc1,
    input  logic        flush,
    input  logic [31:0] src_ready,
    input  logic        stall_A,
    input  logic        stall_B,
    input  logic        commit_A_val,
    input  logic        commit_B_val,
    output logic        A_issued,
    output logic [4:0]  rs0_A,
    output logic [4:0]  rs1_A,
    output logic        rs0_A_en,
    output logic        rs1_A_en,
    output logic [4:0]  rd_A,
    output logic        rd_A_en,
    output logic [1:0]  func_irA,
    output logic        B_issued,
    output logic [4:0]  rs0_B,
    output logic [4:0]  rs1_B,
    output logic        rs0_B_en,
    output logic        rs1_B_en,
    output logic [4:0]  rd_B,
    output logic        rd_B_en,
    output logic [5:0]  rob_free
);

    localparam int unsigned RW  = $clog2(ROB_SLOTS);
    localparam int unsigned MDW = (MD_OCC > 1) ? $clog2(MD_OCC) : 1;

    desc_t           hd;
    desc_t           nx;
    logic            head_val;
    logic            next_val;
    logic [1:0]      deq_cnt;
    logic [RW-1:0]   alloc_ptr;
    logic [RW-1:0]   slot_a;
    logic [RW-1:0]   slot_b;
    logic [MDW-1:0]  md_cnt;
    logic            a_ok;
    logic            b_ok;
    logic            a_alloc;
    logic            b_alloc;
    logic            raw_hazard;
    logic [6:0]      rob_sum;

    riscv_issue_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .enq_val   (enq_val),
        .enq_desc0 (unpack_desc(enq_desc0)),
        .enq_desc1 (unpack_desc(enq_desc1)),
        .deq_cnt   (deq_cnt),
        .enq_rdy   (enq_rdy),
        .head_desc (hd),
        .next_desc (nx),
        .head_val  (head_val),
        .next_val  (next_val)
    );

    assign slot_a = alloc_ptr;
    assign slot_b = alloc_ptr + RW'(a_alloc);

    always_comb begin
        a_ok = !reset && head_val && !stall_A && !flush
            && op_rdy(hd.rs0_en, hd.rs0, src_ready)
            && op_rdy(hd.rs1_en, hd.rs1, src_ready)
            && (hd.func != FU_MULDIV || md_cnt == '0)
            && (!hd.rd_en || rob_free != '0);
        a_alloc = a_ok && hd.rd_en;

        // Head+1 may not read the slot head allocates in the same cycle
        raw_hazard = a_alloc
            && ((nx.rs0_en && nx.rs0 == 5'(slot_a)) || (nx.rs1_en && nx.rs1 == 5'(slot_a)));

        b_ok = a_ok && next_val && nx.func == FU_ALU && !stall_B && !raw_hazard
            && op_rdy(nx.rs0_en, nx.rs0, src_ready)
            && op_rdy(nx.rs1_en, nx.rs1, src_ready)
            && (!nx.rd_en || rob_free >= (a_alloc ? 6'd2 : 6'd1));
        b_alloc = b_ok && nx.rd_en;

        deq_cnt = {1'b0, a_ok} + {1'b0, b_ok};
        rob_sum = 7'(rob_free) + 7'(commit_A_val) + 7'(commit_B_val)
                - 7'(a_alloc) - 7'(b_alloc);
    end

    always_comb begin
        A_issued = a_ok;
        rs0_A    = a_ok ? hd.rs0 : '0;
        rs1_A    = a_ok ? hd.rs1 : '0;
        rs0_A_en = a_ok && hd.rs0_en;
        rs1_A_en = a_ok && hd.rs1_en;
        rd_A     = a_ok ? 5'(slot_a) : '0;
        rd_A_en  = a_alloc;
        func_irA = a_ok ? hd.func : '0;
        B_issued = b_ok;
        rs0_B    = b_ok ? nx.rs0 : '0;
        rs1_B    = b_ok ? nx.rs1 : '0;
        rs0_B_en = b_ok && nx.rs0_en;
        rs1_B_en = b_ok && nx.rs1_en;
        rd_B     = b_ok ? 5'(slot_b) : '0;
        rd_B_en  = b_alloc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_ptr <= '0;
            rob_free  <= 6'(ROB_SLOTS);
            md_cnt    <= '0;
        end else begin
            alloc_ptr <= alloc_ptr + RW'(a_alloc) + RW'(b_alloc);
            // Surplus commits are dropped so the free count stays bounded
            rob_free  <= (rob_sum > 7'(ROB_SLOTS)) ? 6'(ROB_SLOTS) : rob_sum[5:0];
            if (a_ok && hd.func == FU_MULDIV)
                md_cnt <= MDW'(MD_OCC - 1);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - MDW'(1);
        end
    end

    a_rob_overcommit: assert property (@(posedge clk) disable iff (reset)
        rob_sum <= 7'(ROB_SLOTS));

endmodule

// File: tb/tb_riscv_core_issue_sched.sv
// Directed bench for riscv_core_issue_sched: expected issues are queued by the stimulus,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_riscv_core_issue_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  enq_val;
    logic        enq_rdy;
    logic [14:0] enq_desc0, enq_desc1;
    logic        flush;
    logic [31:0] src_ready;
    logic        stall_A, stall_B;
    logic        commit_A_val, commit_B_val;
    logic        A_issued, rs0_A_en, rs1_A_en, rd_A_en;
    logic [4:0]  rs0_A, rs1_A, rd_A;
    logic [1:0]  func_irA;
    logic        B_issued, rs0_B_en, rs1_B_en, rd_B_en;
    logic [4:0]  rs0_B, rs1_B, rd_B;
    logic [5:0]  rob_free;

    typedef struct {
        int          cyc;
        logic [20:0] vec;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    riscv_core_issue_sched #(.QDEPTH(4), .ROB_SLOTS(32), .MD_OCC(4)) dut (
        .clk(clk), .reset(reset), .enq_val(enq_val), .enq_rdy(enq_rdy),
        .enq_desc0(enq_desc0), .enq_desc1(enq_desc1), .flush(flush),
        .src_ready(src_ready), .stall_A(stall_A), .stall_B(stall_B),
        .commit_A_val(commit_A_val), .commit_B_val(commit_B_val),
        .A_issued(A_issued), .rs0_A(rs0_A), .rs1_A(rs1_A), .rs0_A_en(rs0_A_en),
        .rs1_A_en(rs1_A_en), .rd_A(rd_A), .rd_A_en(rd_A_en), .func_irA(func_irA),
        .B_issued(B_issued), .rs0_B(rs0_B), .rs1_B(rs1_B), .rs0_B_en(rs0_B_en),
        .rs1_B_en(rs1_B_en), .rd_B(rd_B), .rd_B_en(rd_B_en), .rob_free(rob_free)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (A_issued || B_issued) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue cyc=%0d A=%0b rd_A=%0d B=%0b rd_B=%0d",
                         cyc, A_issued, rd_A, B_issued, rd_B);
            end else begin
                automatic exp_t e = sbq.pop_front();
                automatic logic [20:0] act = {A_issued, rd_A, rd_A_en, rs0_A, func_irA,
                                              B_issued, rd_B, rd_B_en};
                if (act !== e.vec) begin
                    errors++;
                    $display("FAIL issue_fields cyc=%0d act=%h exp=%h", cyc, act, e.vec);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL issue_cycle act=%0d exp=%0d", cyc, e.cyc);
                end
            end
        end
    end

    function automatic logic [14:0] mk(input logic [1:0] func, input logic rd_en,
                                       input logic rs0_en, input logic [4:0] rs0);
        return {func, rd_en, 1'b0, 5'd0, rs0_en, rs0};
    endfunction

    task automatic expect_issue(input int at, input logic [4:0] ra, input logic [4:0] rs0,
                                input logic [1:0] func, input logic b, input logic [4:0] rb);
        exp_t e;
        e.cyc = at;
        e.vec = {1'b1, ra, 1'b1, rs0, func, b, b ? rb : 5'd0, b};
        sbq.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit chk_out);
        reset = 1'b1; enq_val = '0; flush = 1'b0; stall_A = 1'b0; stall_B = 1'b0;
        commit_A_val = 1'b0; commit_B_val = 1'b0; src_ready = '1;
        if (chk_out) begin
            #1;
            chk("reset_outs_A", 32'({A_issued, rs0_A, rs1_A, rs0_A_en, rs1_A_en,
                                     rd_A, rd_A_en, func_irA}), 32'd0);
            chk("reset_outs_B", 32'({B_issued, rs0_B, rs1_B, rs0_B_en, rs1_B_en,
                                     rd_B, rd_B_en}), 32'd0);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_enq_rdy", 32'(enq_rdy), 32'd1);
        chk("reset_rob_free", 32'(rob_free), 32'd32);
    endtask

    initial begin
        enq_desc0 = '0; enq_desc1 = '0;
        do_reset(1'b1);

        // single ALU
        enq_desc0 = mk(2'b00, 1'b1, 1'b1, 5'd3);
        enq_val = 2'b01;
        expect_issue(cyc + 1, 5'd0, 5'd3, 2'b00, 1'b0, 5'd0);
        tick(); enq_val = '0;
        tick();
        chk("t1_rob_free", 32'(rob_free), 32'd31);

        // independent ALU pair after a fresh reset
        do_reset(1'b0);
        enq_desc0 = mk(2'b00, 1'b1, 1'b1, 5'd3);
        enq_desc1 = mk(2'b00, 1'b1, 1'b1, 5'd4);
        enq_val = 2'b11;
        expect_issue(cyc + 1, 5'd0, 5'd3, 2'b00, 1'b1, 5'd1);
        tick(); enq_val = '0;
        tick();
        chk("t2_rob_free", 32'(rob_free), 32'd30);
        enq_desc0 = mk(2'b00, 1'b1, 1'b1, 5'd6);
        enq_val = 2'b01;
        expect_issue(cyc + 1, 5'd2, 5'd6, 2'b00, 1'b0, 5'd0);
        tick(); enq_val = '0;
        tick();
        chk("t2_rob_free2", 32'(rob_free), 32'd29);

        // same-cycle RAW: desc1 reads slot 0
        do_reset(1'b0);
        enq_desc0 = mk(2'b00, 1'b1, 1'b1, 5'd3);
        enq_desc1 = mk(2'b00, 1'b1, 1'b1, 5'd0);
        enq_val = 2'b11;
        expect_issue(cyc + 1, 5'd0, 5'd3, 2'b00, 1'b0, 5'd0);
        expect_issue(cyc + 2, 5'd1, 5'd0, 2'b00, 1'b0, 5'd0);
        tick(); enq_val = '0;
        tick(); tick();
        chk("t3_rob_free", 32'(rob_free), 32'd30);

        // MULDIV back-to-back
        do_reset(1'b0);
        enq_desc0 = mk(2'b10, 1'b1, 1'b1, 5'd1);
        enq_desc1 = mk(2'b10, 1'b1, 1'b1, 5'd2);
        enq_val = 2'b11;
        expect_issue(cyc + 1, 5'd0, 5'd1, 2'b10, 1'b0, 5'd0);
        expect_issue(cyc + 5, 5'd1, 5'd2, 2'b10, 1'b0, 5'd0);
        tick(); enq_val = '0;
        repeat (6) tick();
        chk("t4_rob_free", 32'(rob_free), 32'd30);

        // exhaust ROB, then one commit lets issue resume at slot 0
        do_reset(1'b0);
        enq_desc0 = mk(2'b00, 1'b1, 1'b0, 5'd0);
        enq_desc1 = mk(2'b00, 1'b1, 1'b0, 5'd0);
        for (int k = 0; k < 16; k++) begin
            enq_val = 2'b11;
            if (k == 8) chk("t5_enq_rdy_stream", 32'(enq_rdy), 32'd1);
            expect_issue(cyc + 1, 5'(2 * k), 5'd0, 2'b00, 1'b1, 5'(2 * k + 1));
            tick();
        end
        enq_desc0 = mk(2'b00, 1'b1, 1'b1, 5'd9);
        enq_val = 2'b01;
        tick(); enq_val = '0;
        chk("t5_rob_empty", 32'(rob_free), 32'd0);
        chk("t5_blocked", 32'(A_issued), 32'd0);
        tick();
        commit_A_val = 1'b1;
        expect_issue(cyc + 1, 5'd0, 5'd9, 2'b00, 1'b0, 5'd0);
        tick(); commit_A_val = 1'b0;
        chk("t5_rob_one", 32'(rob_free), 32'd1);
        tick();
        chk("t5_rob_zero", 32'(rob_free), 32'd0);

        // reset while a stalled instruction sits at the head
        stall_A = 1'b1;
        enq_desc0 = mk(2'b00, 1'b1, 1'b1, 5'd2);
        enq_val = 2'b01;
        tick(); enq_val = '0;
        tick();
        do_reset(1'b1);

        // fill queue under stall, then flush
        stall_A = 1'b1;
        enq_desc0 = mk(2'b00, 1'b1, 1'b0, 5'd0);
        enq_desc1 = mk(2'b00, 1'b1, 1'b0, 5'd0);
        enq_val = 2'b11;
        tick();
        tick(); enq_val = '0;
        chk("t6_full_rdy", 32'(enq_rdy), 32'd0);
        stall_A = 1'b0; flush = 1'b1;
        #1;
        chk("t6_flush_noissue", 32'(A_issued), 32'd0);
        tick(); flush = 1'b0;
        #1;
        chk("t6_post_flush_rdy", 32'(enq_rdy), 32'd1);
        chk("t6_post_flush_empty", 32'(A_issued), 32'd0);
        flush = 1'b1; enq_val = 2'b01;
        tick(); flush = 1'b0; enq_val = '0;
        chk("t6_enq_dropped", 32'(A_issued), 32'd0);
        chk("t6_rob_kept", 32'(rob_free), 32'd32);
        enq_desc0 = mk(2'b00, 1'b1, 1'b1, 5'd5);
        enq_val = 2'b01;
        expect_issue(cyc + 1, 5'd0, 5'd5, 2'b00, 1'b0, 5'd0);
        tick(); enq_val = '0;
        tick();

        for (int w = 0; w < 20 && sbq.size() != 0; w++) tick();
        while (sbq.size() != 0) begin
            automatic exp_t e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_issue exp_cyc=%0d exp=%h", e.cyc, e.vec);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
